remote_supervisor: RTL

// - Master-side counterpart to the reset/watchdog handshake on a slave board's DIO lines.
// - Drives the slave's watchdog line and checks that reset_ack echoes it back in time.
// - Checks the slave's alive_signal waveform (long low, short high), raises a sticky fault on a handshake or waveform error, and can assert instant_reset on the slave.

---
 rtl/remote_supervisor.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/remote_supervisor.sv
// Master-side supervisor for a slave board's reset/watchdog handshake.
// Toggles the slave watchdog line, times the echoed acknowledge, checks the
// slave heartbeat waveform and raises a sticky fault / instant reset request.
//
// Watchdog FSM
//   state          | meaning
//   ST_IDLE        | supervisor or watchdog check disabled, counter cleared
//   ST_WAIT_PERIOD | counting the period until the next watchdog toggle
//   ST_WAIT_ACK    | toggle issued, waiting for the synced ack to follow it
module remote_supervisor #(
    parameter int unsigned WD_PERIOD_CYCLES   = 1250000,
    parameter int unsigned ACK_TIMEOUT_CYCLES = 1250,
    parameter int unsigned MISS_LIMIT         = 3,
    parameter int unsigned ALIVE_LOW_CYCLES   = 12500000,
    parameter int unsigned ALIVE_HIGH_CYCLES  = 1250000,
    parameter int unsigned ALIVE_TOL_CYCLES   = 125000
) (
    input  logic        clk,
    input  logic        peripheral_aresetn,
    input  logic [7:0]  sup_cfg,
    input  logic        reset_ack_in,
    input  logic        alive_signal_in,
    output logic        watchdog_out,
    output logic        instant_reset_out,
    output logic        fault,
    output logic [31:0] sup_sts
);

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_WAIT_PERIOD = 2'd1,
        ST_WAIT_ACK    = 2'd2
    } wd_state_t;

    localparam logic [31:0] WD_LAST    = 32'(WD_PERIOD_CYCLES - 1);
    localparam logic [31:0] ACK_TO     = 32'(ACK_TIMEOUT_CYCLES);
    localparam logic [1:0]  MISS_LIM   = 2'(MISS_LIMIT);
    localparam logic [27:0] LOW_MIN    = 28'(ALIVE_LOW_CYCLES - ALIVE_TOL_CYCLES);
    localparam logic [27:0] LOW_MAX    = 28'(ALIVE_LOW_CYCLES + ALIVE_TOL_CYCLES);
    localparam logic [27:0] HIGH_MIN   = 28'(ALIVE_HIGH_CYCLES - ALIVE_TOL_CYCLES);
    localparam logic [27:0] HIGH_MAX   = 28'(ALIVE_HIGH_CYCLES + ALIVE_TOL_CYCLES);

    // synchronisers
    logic        ack_s1_q, ack_s2_q;
    logic        alive_s1_q, alive_s2_q, alive_prev_q;

    // watchdog FSM state
    wd_state_t   state_q;
    logic [31:0] wd_cnt_q;
    logic        wd_q;
    logic        ack_ref_q;
    logic [15:0] latency_q;

    // alive checker state
    logic [27:0] al_cnt_q;
    logic        armed_q;

    // fault bookkeeping
    logic [1:0]  miss_cnt_q;
    logic        ack_fault_q, alive_short_q, alive_long_q;
    logic        fault_q, instant_q, clr_prev_q;

    // combinational helpers
    logic        wd_active, al_active, clear_req;
    logic        ack_match, ack_timeout, ack_fault_set;
    logic [1:0]  miss_inc;
    logic [15:0] lat_val;
    logic        al_edge;
    logic [27:0] al_cnt_inc, prev_min, prev_max, cur_max;
    logic        short_set, long_set;
    logic        unused_cfg;

    assign unused_cfg = ^sup_cfg[7:5];

    // Double-register the asynchronous slave lines.
    always_ff @(posedge clk or negedge peripheral_aresetn) begin
        if (!peripheral_aresetn) begin
            ack_s1_q     <= 1'b0;
            ack_s2_q     <= 1'b0;
            alive_s1_q   <= 1'b0;
            alive_s2_q   <= 1'b0;
            alive_prev_q <= 1'b0;
        end else begin
            ack_s1_q     <= reset_ack_in;
            ack_s2_q     <= ack_s1_q;
            alive_s1_q   <= alive_signal_in;
            alive_s2_q   <= alive_s1_q;
            alive_prev_q <= alive_s2_q;
        end
    end

    // Event decode for the handshake and the heartbeat checks.
    always_comb begin
        wd_active = sup_cfg[0] & sup_cfg[1];
        al_active = sup_cfg[0] & sup_cfg[2];
        clear_req = sup_cfg[4] & ~clr_prev_q;

        // The ack must move to the new watchdog level; a line that already
        // sat at that level when the toggle went out is not an echo.
        ack_match   = wd_active && (state_q == ST_WAIT_ACK) &&
                      (ack_s2_q == wd_q) && (ack_s2_q != ack_ref_q);
        ack_timeout = wd_active && (state_q == ST_WAIT_ACK) &&
                      !ack_match && (wd_cnt_q >= ACK_TO);
        miss_inc    = (miss_cnt_q == 2'd3) ? 2'd3 : miss_cnt_q + 2'd1;
        ack_fault_set = ack_timeout && (miss_inc >= MISS_LIM);
        lat_val     = (wd_cnt_q > 32'h0000_FFFF) ? 16'hFFFF : wd_cnt_q[15:0];

        al_edge    = alive_s2_q != alive_prev_q;
        al_cnt_inc = (al_cnt_q == 28'hFFF_FFFF) ? al_cnt_q : al_cnt_q + 28'd1;
        // On an edge the phase that just ended had the opposite level.
        prev_min   = alive_s2_q ? LOW_MIN : HIGH_MIN;
        prev_max   = alive_s2_q ? LOW_MAX : HIGH_MAX;
        cur_max    = alive_s2_q ? HIGH_MAX : LOW_MAX;
        short_set  = al_active && al_edge && armed_q && (al_cnt_q < prev_min);
        long_set   = al_active && ((al_edge && armed_q && (al_cnt_q > prev_max)) ||
                                   (!al_edge && (al_cnt_inc > cur_max)));
    end

    // Watchdog FSM: period timer, toggle, ack wait and latency capture.
    always_ff @(posedge clk or negedge peripheral_aresetn) begin
        if (!peripheral_aresetn) begin
            state_q   <= ST_IDLE;
            wd_cnt_q  <= 32'd0;
            wd_q      <= 1'b0;
            ack_ref_q <= 1'b0;
            latency_q <= 16'd0;
        end else if (!wd_active) begin
            state_q  <= ST_IDLE;
            wd_cnt_q <= 32'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_q  <= ST_WAIT_PERIOD;
                    wd_cnt_q <= 32'd0;
                end
                ST_WAIT_PERIOD: begin
                    if (wd_cnt_q >= WD_LAST) begin
                        wd_q      <= ~wd_q;
                        ack_ref_q <= ack_s2_q;
                        // the first WAIT_ACK cycle is one cycle after the toggle
                        wd_cnt_q  <= 32'd1;
                        state_q   <= ST_WAIT_ACK;
                    end else begin
                        wd_cnt_q <= wd_cnt_q + 32'd1;
                    end
                end
                ST_WAIT_ACK: begin
                    if (ack_match) begin
                        latency_q <= lat_val;
                        wd_cnt_q  <= 32'd0;
                        state_q   <= ST_WAIT_PERIOD;
                    end else if (ack_timeout) begin
                        wd_cnt_q  <= 32'd0;
                        state_q   <= ST_WAIT_PERIOD;
                    end else begin
                        wd_cnt_q  <= wd_cnt_q + 32'd1;
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    wd_cnt_q <= 32'd0;
                end
            endcase
        end
    end

    // Heartbeat phase counter and arming.
    always_ff @(posedge clk or negedge peripheral_aresetn) begin
        if (!peripheral_aresetn) begin
            al_cnt_q <= 28'd0;
            armed_q  <= 1'b0;
        end else if (!al_active) begin
            al_cnt_q <= 28'd0;
            armed_q  <= 1'b0;
        end else if (al_edge) begin
            // the edge cycle is already the first cycle of the new phase
            al_cnt_q <= 28'd1;
            armed_q  <= 1'b1;
        end else begin
            al_cnt_q <= al_cnt_inc;
            if (clear_req) begin
                armed_q <= 1'b0;
            end
        end
    end

    // Sticky fault flags, miss counter and registered fault outputs.
    always_ff @(posedge clk or negedge peripheral_aresetn) begin
        if (!peripheral_aresetn) begin
            miss_cnt_q    <= 2'd0;
            ack_fault_q   <= 1'b0;
            alive_short_q <= 1'b0;
            alive_long_q  <= 1'b0;
            fault_q       <= 1'b0;
            instant_q     <= 1'b0;
            clr_prev_q    <= 1'b0;
        end else begin
            clr_prev_q <= sup_cfg[4];
            if (ack_timeout) begin
                miss_cnt_q <= miss_inc;
            end else if (ack_match || clear_req) begin
                miss_cnt_q <= 2'd0;
            end
            ack_fault_q   <= ack_fault_set | (ack_fault_q & ~clear_req);
            alive_short_q <= short_set | (alive_short_q & ~clear_req);
            alive_long_q  <= long_set | (alive_long_q & ~clear_req);
            fault_q       <= ack_fault_q | alive_short_q | alive_long_q;
            instant_q     <= fault_q & sup_cfg[3];
        end
    end

    assign watchdog_out      = wd_q;
    assign fault             = fault_q;
    assign instant_reset_out = instant_q;
    assign sup_sts = {latency_q, 4'b0000, miss_cnt_q, state_q, armed_q,
                      alive_s2_q, ack_s2_q, wd_q, alive_long_q, alive_short_q,
                      ack_fault_q, fault_q};

endmodule
